// File: rtl/pri_sched_pkg.sv
// rtl/pri_sched_pkg.sv - shared types and constants for the priority register scheduler
package pri_sched_pkg;

  localparam int NUM_REGS = 16;
  localparam int IDX_W    = 4;

  localparam logic [1:0] PRI_DS_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    DONE
  } state_t;

endpackage

// File: rtl/pri_pending_enc.sv
// rtl/pri_pending_enc.sv - lowest-set-bit encoder selecting the next pending shadow entry
module pri_pending_enc
  import pri_sched_pkg::*;
(
  input  logic [NUM_REGS-1:0] bits,
  output logic [IDX_W-1:0]    idx,
  output logic                any
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx = '0;
    any = |bits;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (bits[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/pri_reg_scheduler.sv
// rtl/pri_reg_scheduler.sv - frame-synchronous shadow bank replaying dirty entries into the mixer
// Optional raster-split copy trigger when PRI_RASTER_SPLIT_EN is defined.
module pri_reg_scheduler
  import pri_sched_pkg::*;
#(
  parameter int WRITE_GAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_cs,
  input  logic [IDX_W-1:0] cpu_addr,
  input  logic [7:0]       cpu_din,
  input  logic             cpu_rw,
  input  logic [1:0]       cpu_ds_n,
  output logic [7:0]       cpu_dout,
  input  logic             vblank,
`ifdef PRI_RASTER_SPLIT_EN
  input  logic [8:0]       line,
  input  logic [8:0]       split_line,
  input  logic             split_en,
`endif
  input  logic             sync_all,
  output logic             pri_cs,
  output logic [IDX_W-1:0] pri_addr,
  output logic [7:0]       pri_din,
  output logic             pri_rw,
  output logic [1:0]       pri_ds_n,
  output logic             busy,
  output logic             copy_done
);

  localparam int GAP_W = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (WRITE_GAP > 1) ? GAP_W'(WRITE_GAP - 1) : '0;

  state_t              state, state_next;
  logic [NUM_REGS-1:0] dirty, dirty_next;
  logic [NUM_REGS-1:0] pending, pending_next;
  logic                retrig, retrig_next;
  logic                busy_next;
  logic [GAP_W-1:0]    gap_cnt;
  logic                vblank_q;
  logic                trigger;
  logic                load;
  logic                issue;
  logic                cpu_we;
  logic [IDX_W-1:0]    idx;
  logic                any;
  logic [7:0]          shadow [NUM_REGS];
  logic                unused_ds_hi;

  assign unused_ds_hi = cpu_ds_n[1];
  assign cpu_we       = cpu_cs && !cpu_rw && !cpu_ds_n[0];

`ifdef PRI_RASTER_SPLIT_EN
  logic split_hit, split_hit_q;
  assign split_hit = split_en && (line == split_line);
  assign trigger   = (vblank && !vblank_q) || (split_hit && !split_hit_q);
`else
  assign trigger   = vblank && !vblank_q;
`endif

  pri_pending_enc u_enc (
    .bits (pending),
    .idx  (idx),
    .any  (any)
  );

  always_comb begin
    state_next   = state;
    dirty_next   = dirty;
    pending_next = pending;
    retrig_next  = retrig;
    busy_next    = busy;
    load         = 1'b0;
    issue        = 1'b0;

    case (state)
      IDLE: begin
        if (trigger && dirty != '0) begin
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        issue              = any;
        pending_next[idx]  = 1'b0;
        if (pending_next == '0)  state_next = DONE;
        else if (WRITE_GAP > 0)  state_next = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_next = ISSUE;
      end
      DONE: begin
        busy_next   = 1'b0;
        retrig_next = 1'b0;
        // A trigger landing in DONE itself is folded in rather than lost.
        if ((retrig || trigger) && dirty != '0) begin
          load       = 1'b1;
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (trigger && (state == ISSUE || state == GAP)) retrig_next = 1'b1;

    if (load) begin
      pending_next = dirty;
      dirty_next   = '0;
      busy_next    = 1'b1;
    end

    if (cpu_we)   dirty_next[cpu_addr] = 1'b1;
    if (sync_all) dirty_next = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dirty    <= '0;
      pending  <= '0;
      retrig   <= 1'b0;
      busy     <= 1'b0;
      gap_cnt  <= '0;
      vblank_q <= 1'b0;
    end else begin
      state    <= state_next;
      dirty    <= dirty_next;
      pending  <= pending_next;
      retrig   <= retrig_next;
      busy     <= busy_next;
      gap_cnt  <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
      vblank_q <= vblank;
    end
  end

`ifdef PRI_RASTER_SPLIT_EN
  always_ff @(posedge clk) begin
    if (reset) split_hit_q <= 1'b0;
    else       split_hit_q <= split_hit;
  end
`endif

  // Mixer port is fully registered; shadow is read before a same-cycle CPU write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      cpu_dout  <= '0;
      pri_cs    <= 1'b0;
      pri_addr  <= '0;
      pri_din   <= '0;
      pri_rw    <= 1'b1;
      pri_ds_n  <= 2'b11;
      copy_done <= 1'b0;
    end else begin
      if (cpu_we)           shadow[cpu_addr] <= cpu_din;
      if (cpu_cs && cpu_rw) cpu_dout <= shadow[cpu_addr];
      pri_cs   <= issue;
      pri_rw   <= !issue;
      pri_ds_n <= issue ? PRI_DS_WRITE : 2'b11;
      if (issue) begin
        pri_addr <= idx;
        pri_din  <= shadow[idx];
      end
      copy_done <= (state == DONE);
    end
  end

endmodule

// File: doc/pri_reg_scheduler.md
Name: pri_reg_scheduler

Overview:
Frame-synchronous register scheduler for the TC0360PRI priority mixer.
- CPU writes land in a 16x8 shadow bank and are marked dirty.
- On vblank rise, only the dirty entries are replayed into the mixer's register bus, so priority changes never tear mid-frame.
- Sits between the 68k bus decode and the mixer's cs/addr/din/rw/ds_n port.

Parameters:
NUM_REGS, 16, shadow entries. The RTL supports 16 only (4-bit address).
WRITE_GAP, 1, idle cycles between consecutive mixer writes. 0 means back-to-back.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cpu_cs  in  1  CPU select for the priority register window
cpu_addr  in  4  register index
cpu_din  in  8  write data (low byte lane)
cpu_rw  in  1  1=read, 0=write
cpu_ds_n  in  2  data strobes, active low; bit0 = low byte
cpu_dout  out  8  shadow readback
vblank  in  1  video vblank level
sync_all  in  1  pulse: mark all 16 entries dirty (savestate restore)
pri_cs  out  1  mixer select
pri_addr  out  4  mixer register index
pri_din  out  8  mixer write data
pri_rw  out  1  mixer rw, always 0 when pri_cs=1
pri_ds_n  out  2  2'b10 when pri_cs=1
busy  out  1  copy sequence active
copy_done  out  1  one-cycle pulse at end of a copy

Behaviour:
Reset (clk, reset):
- All shadow entries cleared to 0; dirty, pending and retrigger cleared.
- Outputs: cpu_dout=0, pri_cs=0, pri_addr=0, pri_din=0, pri_rw=1, pri_ds_n=2'b11, busy=0, copy_done=0.
- Reset mid-copy aborts the sequence immediately. No partial write is issued in the cycle reset is high.

CPU side:
- Write (cpu_cs & ~cpu_rw & ~cpu_ds_n[0]): shadow[addr]<=din and dirty[addr]<=1.
- cpu_ds_n[0]=1 ignores the write.
- Read (cpu_cs & cpu_rw): cpu_dout<=shadow[addr], one-cycle latency. cpu_dout holds otherwise.

vblank edge:
- vblank is registered; rise = vblank & ~vblank_q.

States:
- IDLE:
  - On rise with dirty!=0: pending<=dirty, dirty<=0, busy<=1, go to ISSUE.
  - On rise with dirty==0: stay idle, no pulse.
- ISSUE:
  - idx = lowest set bit of pending.
  - Drive pri_cs=1, pri_addr=idx, pri_din=shadow[idx] for exactly one cycle; clear pending[idx].
  - If the remaining pending==0, go to DONE.
  - Else go to GAP if WRITE_GAP>0, else stay in ISSUE.
- GAP: count WRITE_GAP cycles with pri_cs=0, then return to ISSUE.
- DONE:
  - One cycle; copy_done=1, busy<=0.
  - If retrigger is set and dirty!=0, clear retrigger and load pending as in IDLE (no idle cycle between).
  - Otherwise go to IDLE.

Timing:
- Mixer outputs are registered.
- vblank rise sampled at cycle N → first pri_cs at N+2.
- K dirty entries finish at N+2+(K-1)*(WRITE_GAP+1); copy_done follows one cycle after the last write.

Boundary conditions:
- CPU write to index j while busy: shadow and dirty[j] update.
  - If j is still pending, the mixer receives the new value and dirty[j] is also set, producing a harmless repeat next frame.
  - A write in the same cycle j is issued: the mixer gets the old value; dirty[j]=1 remains set.
- vblank rise while busy sets retrigger.
- sync_all: dirty<=16'hFFFF; takes precedence over a same-cycle CPU write's dirty update (same result).
- pri_rw returns to 1 and pri_ds_n to 2'b11 whenever pri_cs=0.

Optional Feature:
PRI_RASTER_SPLIT_EN
- Enabled: adds inputs line[8:0], split_line[8:0], split_en.
- A copy trigger also fires on the first cycle line==split_line while split_en=1 (edge-detected on the line compare). It behaves identically to a vblank rise, including retrigger.
- Disabled: ports absent; vblank is the only trigger.

Decomposition:
Package pri_sched_pkg:
- state enum {IDLE, ISSUE, GAP, DONE}
- NUM_REGS and IDX_W constants
- PRI_DS_WRITE=2'b10

Sub-module pri_pending_enc: combinational 16-bit lowest-set-bit encoder with outputs idx[3:0] and any.

Test Plan:
1. Reset, then CPU writes addr 4=8'h21 and addr 9=8'h43, then vblank rise → exactly two mixer writes, (4,21) then (9,43), spaced 2 cycles (WRITE_GAP=1); copy_done one cycle after the second write; busy low afterwards.
2. vblank rise with no writes pending → pri_cs never asserts, no copy_done.
3. sync_all, then vblank → 16 writes at addresses 0..15 in order, data = shadow contents.
4. During a copy, CPU writes addr 9=8'h55 before 9 issues → mixer gets 55; next vblank re-sends (9,55).
5. Second vblank rise while busy → a second copy starts immediately after DONE and covers writes made during the first copy.
6. Reset asserted during a 16-entry copy → pri_cs=0 next cycle, cpu_dout=0, shadow reads back 0; next vblank issues nothing.
